// File: rtl/fp32_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : fp32_add_seq_if
// Brief   : Issue/writeback handshake bundle for the FP32 add/sub sequencer.
// Revision: 1.0
// ============================================================================
interface fp32_add_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         swap_sel;
  logic         busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, swap_sel, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, swap_sel, busy
  );
endinterface
`default_nettype wire

// File: rtl/fp32_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : fp32_add_seq
// Brief   : Multi-cycle FP32 add/sub, one align/normalize shift per cycle.
//           Define FP_ADD_RNE_EN for round-to-nearest-even (default truncates).
// Revision: 1.0
// ============================================================================
module fp32_add_seq #(
  parameter int EXP_W     = 8,
  parameter int FRAC_W    = 23,
  parameter int ALIGN_MAX = 27
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  fp32_add_seq_if.slave bus
);

  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int EXT_W  = SIG_W + 3;
  localparam int SUM_W  = EXT_W + 1;
  localparam int DIFF_W = $clog2(ALIGN_MAX + 1);

  localparam logic [EXP_W-1:0]  c_EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]  c_ALIGN_E = EXP_W'(ALIGN_MAX);
  localparam logic [DIFF_W-1:0] c_ALIGN_D = DIFF_W'(ALIGN_MAX);
  localparam logic [W-1:0]      c_QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CHECK = 3'd1;
  localparam logic [2:0] c_SWAP  = 3'd2;
  localparam logic [2:0] c_ALIGN = 3'd3;
  localparam logic [2:0] c_ADD   = 3'd4;
  localparam logic [2:0] c_NORM  = 3'd5;
  localparam logic [2:0] c_ROUND = 3'd6;
  localparam logic [2:0] c_DONE  = 3'd7;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nx;

  logic              r_sa, r_sb;
  logic [EXP_W-1:0]  r_ea, r_eb;
  logic [FRAC_W-1:0] r_fa, r_fb;
  logic [EXT_W-1:0]  r_large, r_small;
  logic              r_sticky;
  logic [DIFF_W-1:0] r_diff;
  logic [EXP_W-1:0]  r_exp;
  logic              r_sign;
  logic              r_eff_sub;
  logic [SUM_W-1:0]  r_sum;
  logic [W-1:0]      r_result;
  logic              r_swap;

  logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic              w_special;
  logic [W-1:0]      w_special_res;
  logic              w_swap;
  logic [EXP_W-1:0]  w_e_large, w_e_small, w_exp_diff;
  logic [FRAC_W-1:0] w_f_large, w_f_small;
  logic              w_s_large;
  logic [DIFF_W-1:0] w_diff_clip;
  logic [EXT_W-1:0]  w_small_sh;
  logic              w_align_last;
  logic [EXP_W-1:0]  w_exp_inc, w_exp_dec;
  logic [W-1:0]      w_round_res;

  // Operand classification on the captured (sign-adjusted) operands
  assign w_nan_a  = (r_ea == c_EXP_MAX) && (r_fa != '0);
  assign w_nan_b  = (r_eb == c_EXP_MAX) && (r_fb != '0);
  assign w_inf_a  = (r_ea == c_EXP_MAX) && (r_fa == '0);
  assign w_inf_b  = (r_eb == c_EXP_MAX) && (r_fb == '0);
  assign w_zero_a = (r_ea == '0);
  assign w_zero_b = (r_eb == '0);

  always_comb begin
    w_special     = 1'b1;
    w_special_res = '0;
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (r_sa != r_sb))) begin
      w_special_res = c_QNAN;
    end else if (w_inf_a) begin
      w_special_res = {r_sa, c_EXP_MAX, {FRAC_W{1'b0}}};
    end else if (w_inf_b) begin
      w_special_res = {r_sb, c_EXP_MAX, {FRAC_W{1'b0}}};
    end else if (w_zero_a && w_zero_b) begin
      w_special_res = {r_sa & r_sb, {(W-1){1'b0}}};
    end else if (w_zero_a) begin
      w_special_res = {r_sb, r_eb, r_fb};
    end else if (w_zero_b) begin
      w_special_res = {r_sa, r_ea, r_fa};
    end else begin
      w_special = 1'b0;
    end
  end

  // Magnitude compare drives the swap mux; equal magnitudes keep a on the large path
  assign w_swap      = {r_eb, r_fb} > {r_ea, r_fa};
  assign w_e_large   = w_swap ? r_eb : r_ea;
  assign w_e_small   = w_swap ? r_ea : r_eb;
  assign w_f_large   = w_swap ? r_fb : r_fa;
  assign w_f_small   = w_swap ? r_fa : r_fb;
  assign w_s_large   = w_swap ? r_sb : r_sa;
  assign w_exp_diff  = w_e_large - w_e_small;
  assign w_diff_clip = (w_exp_diff > c_ALIGN_E) ? c_ALIGN_D : w_exp_diff[DIFF_W-1:0];

  assign w_small_sh   = r_small >> 1;
  assign w_align_last = (r_diff == DIFF_W'(1)) || (w_small_sh == '0);
  assign w_exp_inc    = r_exp + EXP_W'(1);
  assign w_exp_dec    = r_exp - EXP_W'(1);

`ifdef FP_ADD_RNE_EN
  logic              w_inc;
  logic [SIG_W:0]    w_rnd;
  logic [EXP_W-1:0]  w_rnd_exp;
  logic [FRAC_W-1:0] w_rnd_frac;

  // G=bit2, R=bit1, S=bit0|sticky; a carry out of the significand bumps the exponent
  always_comb begin
    w_inc       = r_sum[2] && (r_sum[1] || r_sum[0] || r_sticky || r_sum[3]);
    w_rnd       = {1'b0, r_sum[EXT_W-1:3]} + {{SIG_W{1'b0}}, w_inc};
    w_rnd_exp   = w_rnd[SIG_W] ? w_exp_inc : r_exp;
    w_rnd_frac  = w_rnd[SIG_W] ? w_rnd[SIG_W-1:1] : w_rnd[FRAC_W-1:0];
    if (w_rnd_exp == c_EXP_MAX) begin
      w_round_res = {r_sign, c_EXP_MAX, {FRAC_W{1'b0}}};
    end else begin
      w_round_res = {r_sign, w_rnd_exp, w_rnd_frac};
    end
  end
`else
  wire logic w_unused_grs = ^{r_sum[2:0], r_sticky};

  assign w_round_res = {r_sign, r_exp, r_sum[EXT_W-2:3]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      c_IDLE:  if (bus.in_valid) w_state_nx = c_CHECK;
      c_CHECK: w_state_nx = w_special ? c_DONE : c_SWAP;
      c_SWAP:  w_state_nx = (w_exp_diff == '0) ? c_ADD : c_ALIGN;
      c_ALIGN: if (w_align_last) w_state_nx = c_ADD;
      c_ADD:   w_state_nx = c_NORM;
      c_NORM: begin
        if (r_sum[SUM_W-1]) begin
          w_state_nx = (w_exp_inc == c_EXP_MAX) ? c_DONE : c_ROUND;
        end else if (r_sum == '0) begin
          w_state_nx = c_DONE;
        end else if (!r_sum[SUM_W-2]) begin
          if (w_exp_dec == '0) begin
            w_state_nx = c_DONE;
          end else if (r_sum[SUM_W-3]) begin
            w_state_nx = c_ROUND;
          end
        end else begin
          w_state_nx = c_ROUND;
        end
      end
      c_ROUND: w_state_nx = c_DONE;
      c_DONE:  if (bus.out_ready) w_state_nx = c_IDLE;
      default: w_state_nx = c_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == c_IDLE);
    bus.busy      = (r_state != c_IDLE);
    bus.out_valid = (r_state == c_DONE);
    bus.result    = r_result;
    bus.swap_sel  = r_swap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_ea      <= '0;
      r_eb      <= '0;
      r_fa      <= '0;
      r_fb      <= '0;
      r_large   <= '0;
      r_small   <= '0;
      r_sticky  <= 1'b0;
      r_diff    <= '0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      r_eff_sub <= 1'b0;
      r_sum     <= '0;
      r_result  <= '0;
      r_swap    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.in_valid) begin
            r_sa   <= bus.a[W-1];
            r_ea   <= bus.a[W-2:FRAC_W];
            r_fa   <= bus.a[FRAC_W-1:0];
            r_sb   <= bus.b[W-1] ^ bus.sub;
            r_eb   <= bus.b[W-2:FRAC_W];
            r_fb   <= bus.b[FRAC_W-1:0];
            r_swap <= 1'b0;
          end
        end
        c_CHECK: begin
          if (w_special) r_result <= w_special_res;
        end
        c_SWAP: begin
          r_swap    <= w_swap;
          r_large   <= {1'b1, w_f_large, 3'b000};
          r_small   <= {1'b1, w_f_small, 3'b000};
          r_diff    <= w_diff_clip;
          r_exp     <= w_e_large;
          r_sign    <= w_s_large;
          r_eff_sub <= r_sa ^ r_sb;
          r_sticky  <= 1'b0;
        end
        c_ALIGN: begin
          r_small  <= w_small_sh;
          r_sticky <= r_sticky | r_small[0];
          r_diff   <= r_diff - DIFF_W'(1);
        end
        c_ADD: begin
          // large >= small in magnitude, so the difference never goes negative
          r_sum <= r_eff_sub ? ({1'b0, r_large} - {1'b0, r_small})
                             : ({1'b0, r_large} + {1'b0, r_small});
        end
        c_NORM: begin
          if (r_sum[SUM_W-1]) begin
            r_sum    <= r_sum >> 1;
            r_sticky <= r_sticky | r_sum[0];
            r_exp    <= w_exp_inc;
            if (w_exp_inc == c_EXP_MAX) r_result <= {r_sign, c_EXP_MAX, {FRAC_W{1'b0}}};
          end else if (r_sum == '0) begin
            r_result <= '0;
          end else if (!r_sum[SUM_W-2]) begin
            r_sum <= r_sum << 1;
            r_exp <= w_exp_dec;
            if (w_exp_dec == '0) r_result <= {r_sign, {(W-1){1'b0}}};
          end
        end
        c_ROUND: begin
          r_result <= w_round_res;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp32_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp32_add_seq
// Brief   : Directed + randomized bench for fp32_add_seq against a numeric model.
// Revision: 1.0
// ============================================================================
module tb_fp32_add_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  fp32_add_seq_if #(.W(32)) ifc ();

  fp32_add_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

`ifdef FP_ADD_RNE_EN
  localparam logic [31:0] EXP_ROUND_UP = 32'h3F800001;
`else
  localparam logic [31:0] EXP_ROUND_UP = 32'h3F800000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Numeric reference: exact integer significands, explicit guard/round/sticky
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, output logic special,
                                          output logic swp);
    logic sx, sy, sl, st;
    int ex, ey, el, es, d, e;
    longint unsigned fx, fy, ml, ms, sum, mant;
    sx = x[31];
    sy = y[31] ^ s;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = 64'(x[22:0]);
    fy = 64'(y[22:0]);
    special = 1'b1;
    swp = 1'b0;
    if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0)) return 32'h7FC00000;
    if (ex == 255 && ey == 255 && sx != sy) return 32'h7FC00000;
    if (ex == 255) return {sx, 8'hFF, 23'h0};
    if (ey == 255) return {sy, 8'hFF, 23'h0};
    if (ex == 0 && ey == 0) return {sx & sy, 31'h0};
    if (ex == 0) return {sy, y[30:0]};
    if (ey == 0) return {sx, x[30:0]};
    special = 1'b0;
    swp = (y[30:0] > x[30:0]);
    if (swp) begin
      el = ey; es = ex; ml = fy; ms = fx; sl = sy;
    end else begin
      el = ex; es = ey; ml = fx; ms = fy; sl = sx;
    end
    ml = (ml + 64'd8388608) * 64'd8;
    ms = (ms + 64'd8388608) * 64'd8;
    d = el - es;
    if (d > 27) d = 27;
    st = 1'b0;
    while (d > 0 && ms != 0) begin
      st = st | ms[0];
      ms = ms / 64'd2;
      d--;
    end
    sum = (sx != sy) ? (ml - ms) : (ml + ms);
    e = el;
    if (sum >= 64'd134217728) begin
      st = st | sum[0];
      sum = sum / 64'd2;
      e++;
      if (e == 255) return {sl, 8'hFF, 23'h0};
    end else if (sum == 0) begin
      return 32'h0;
    end else begin
      while (sum < 64'd67108864) begin
        sum = sum * 64'd2;
        e--;
        if (e == 0) return {sl, 31'h0};
      end
    end
    mant = sum / 64'd8;
`ifdef FP_ADD_RNE_EN
    if (sum[2] && (sum[1] || sum[0] || st || mant[0])) mant = mant + 64'd1;
    if (mant == 64'd16777216) begin
      mant = mant / 64'd2;
      e++;
      if (e == 255) return {sl, 8'hFF, 23'h0};
    end
`endif
    return {sl, e[7:0], mant[22:0]};
  endfunction

  // Issues one operation, checks result against exp_res; hold>0 applies backpressure
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                       input int hold, input logic [31:0] exp_res, input string tag,
                       output logic swp, output int lat);
    int k;
    k = 0;
    while (!ifc.in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    ifc.a = x;
    ifc.b = y;
    ifc.sub = s;
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    lat = 1;
    while (!ifc.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_valid_seen"}, {31'b0, ifc.out_valid}, 32'd1);
    chk({tag, "_result"}, ifc.result, exp_res);
    swp = ifc.swap_sel;
    for (int h = 0; h < hold; h++) begin
      ifc.in_valid = 1'b1;
      ifc.a = $urandom;
      ifc.b = $urandom;
      @(posedge clk); #1;
      chk("bp_result", ifc.result, exp_res);
      chk("bp_out_valid", {31'b0, ifc.out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, ifc.in_ready}, 32'd0);
    end
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    ifc.in_valid = 1'b0;
    if (hold > 0) begin
      chk("bp_release_in_ready", {31'b0, ifc.in_ready}, 32'd1);
      chk("bp_release_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    end
  endtask

  logic [31:0] ta [0:7] = '{32'h00000001, 32'h80000000, 32'h00000000, 32'h7FC12345,
                             32'h3F800000, 32'h3F800000, 32'h00800000, 32'h7F800000};
  logic [31:0] tb [0:7] = '{32'h3F800000, 32'h80000000, 32'h80000000, 32'h3F800000,
                             32'hFF800000, 32'h3F400000, 32'h00C00000, 32'h7F800000};
  logic        ts [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] te [0:7] = '{32'h3F800000, 32'h80000000, 32'h00000000, 32'h7FC00000,
                             32'hFF800000, 32'h3E800000, 32'h80000000, 32'h7FC00000};

  initial begin
    logic [31:0] x, y, e;
    logic        s, sp, sw, swp;
    int          lat, tmp;

    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.a = '0;
    ifc.b = '0;
    ifc.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, ifc.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("rst_result", ifc.result, 32'h0);
    chk("rst_swap_sel", {31'b0, ifc.swap_sel}, 32'd0);
    chk("rst_busy", {31'b0, ifc.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency is counted with the accept edge as edge 1
    do_op(32'h3F800000, 32'h3F800000, 1'b0, 0, 32'h40000000, "one_plus_one", swp, lat);
    chk("one_plus_one_swap", {31'b0, swp}, 32'd0);
    chk("one_plus_one_latency", lat, 32'd6);

    do_op(32'h3F800000, 32'h40400000, 1'b0, 0, 32'h40800000, "one_plus_three", swp, lat);
    chk("one_plus_three_swap", {31'b0, swp}, 32'd1);
    do_op(32'h3FC00000, 32'h3FC00000, 1'b1, 0, 32'h00000000, "cancel", swp, lat);

    do_op(32'h7F800000, 32'hFF800000, 1'b0, 0, 32'h7FC00000, "inf_minus_inf", swp, lat);
    chk("special_latency", lat, 32'd2);
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0, 32'h7F800000, "overflow", swp, lat);

    do_op(32'h3F800000, 32'h3F800000, 1'b0, 5, 32'h40000000, "backpressure", swp, lat);
    do_op(32'h40000000, 32'h3F800000, 1'b1, 0, 32'h3F800000, "after_bp", swp, lat);

    // Abort during alignment: 20 shifts pending, reset lands a few cycles in
    ifc.a = 32'h3F800000;
    ifc.b = 32'h35800000;
    ifc.sub = 1'b0;
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_op_busy", {31'b0, ifc.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("abort_busy", {31'b0, ifc.busy}, 32'd0);
    chk("abort_in_ready", {31'b0, ifc.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'h3F800000, 32'h3F800000, 1'b0, 0, 32'h40000000, "rerun", swp, lat);
    chk("rerun_latency", lat, 32'd6);

    do_op(32'h3F800000, 32'h33C00000, 1'b0, 0, EXP_ROUND_UP, "round_above_half", swp, lat);
    do_op(32'h3F800000, 32'h33800000, 1'b0, 0, 32'h3F800000, "round_tie_even", swp, lat);

    for (int i = 0; i < 8; i++) begin
      do_op(ta[i], tb[i], ts[i], 0, te[i], "table", swp, lat);
    end

    for (int i = 0; i < 48; i++) begin
      x = $urandom;
      y = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i % 4 == 1) begin
        tmp = int'(x[30:23]) + int'($urandom_range(0, 60)) - 30;
        if (tmp < 1) tmp = 1;
        if (tmp > 254) tmp = 254;
        y[30:23] = tmp[7:0];
      end else if (i % 4 == 2) begin
        y[30:0] = x[30:0] ^ ($urandom & 32'h0000_03FF);
      end else if (i % 4 == 3) begin
        x[30:23] = 8'(100 + $urandom_range(0, 40));
        y[30:23] = 8'(100 + $urandom_range(0, 40));
      end
      e = ref_add(x, y, s, sp, sw);
      do_op(x, y, s, 0, e, "rand", swp, lat);
      if (!sp) chk("rand_swap", {31'b0, swp}, {31'b0, sw});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
